// File: rtl/ama_riscv_fetch.sv
// rtl/ama_riscv_fetch.sv - instruction fetch unit with IMEM request channel and instruction FIFO
//
// Owns the fetch PC, issues word requests to IMEM under a credit limit, and buffers
// in-order responses in a BUF_DEPTH-entry FIFO whose head feeds the decoder.
// Optional feature macro: AMA_RISCV_FETCH_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_pc_sel[1:0]             PC_SEL_INC4 / PC_SEL_ALU / PC_SEL_START_ADDR (redirect on ALU/START)
//   i_pc_we                   0: no new IMEM request this cycle
//   i_stall_if                1: hold FIFO head
//   i_clear_if                1: pop head, present NOP with valid low
//   i_alu_out[31:0]           redirect target for PC_SEL_ALU
//   o_imem_req_valid/i_imem_req_ready/o_imem_req_addr[31:0]   IMEM request channel
//   i_imem_rsp_valid/i_imem_rsp_data[31:0]                    IMEM in-order response
//   o_inst_id[31:0], o_pc_id[31:0], o_inst_valid_id           decoder side
//   o_perf_stall_cnt/o_perf_flush_cnt/o_perf_drop_cnt[31:0]   only with AMA_RISCV_FETCH_PERF_EN

`ifndef PC_SEL_INC4
`define PC_SEL_INC4       2'd0
`endif
`ifndef PC_SEL_ALU
`define PC_SEL_ALU        2'd1
`endif
`ifndef PC_SEL_START_ADDR
`define PC_SEL_START_ADDR 2'd2
`endif

module ama_riscv_fetch #(
    parameter logic [31:0] START_ADDR = 32'h0000_0000,
    parameter int          BUF_DEPTH  = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_pc_sel,
    input  logic        i_pc_we,
    input  logic        i_stall_if,
    input  logic        i_clear_if,
    input  logic [31:0] i_alu_out,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic [31:0] o_inst_id,
    output logic [31:0] o_pc_id,
    output logic        o_inst_valid_id
`ifdef AMA_RISCV_FETCH_PERF_EN
    ,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_flush_cnt,
    output logic [31:0] o_perf_drop_cnt
`endif
);

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    typedef enum logic [1:0] {S_RESET, S_RUN, S_REDIR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [31:0]   r_fpc;
    logic [31:0]   r_rsp_pc;     // PC of the oldest outstanding request
    logic [31:0]   r_pc_last;
    logic [31:0]   r_buf_inst [BUF_DEPTH];
    logic [31:0]   r_buf_pc   [BUF_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_drop;

    logic          w_redir;
    logic [31:0]   w_target;
    logic [CW:0]   w_inflight;
    logic          w_credit;
    logic          w_empty;
    logic          w_req_valid;
    logic          w_accept;
    logic          w_rsp_drop;
    logic          w_push;
    logic          w_pop;

    assign w_redir    = (i_pc_sel == `PC_SEL_ALU) || (i_pc_sel == `PC_SEL_START_ADDR);
    assign w_target   = (i_pc_sel == `PC_SEL_ALU) ? (i_alu_out & ~32'h3) : START_ADDR;
    assign w_inflight = {1'b0, r_count} + {1'b0, r_outst};
    assign w_credit   = w_inflight < (CW+1)'(BUF_DEPTH);
    assign w_empty    = (r_count == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_req_valid = 1'b0;
        case (r_state)
            S_RESET: w_state_nxt = w_redir ? S_REDIR : S_RUN;
            S_RUN: begin
                w_req_valid = i_pc_we && w_credit && !w_redir;
                w_state_nxt = w_redir ? S_REDIR : S_RUN;
            end
            S_REDIR: w_state_nxt = w_redir ? S_REDIR : S_RUN;
            default: w_state_nxt = S_RESET;
        endcase
    end

    assign w_accept   = w_req_valid && i_imem_req_ready;
    // Responses to requests issued before a redirect are discarded, including one
    // landing in the redirect cycle itself.
    assign w_rsp_drop = i_imem_rsp_valid && (w_redir || (r_drop != '0));
    assign w_push     = i_imem_rsp_valid && !w_rsp_drop;
    assign w_pop      = !w_redir && !w_empty && (!i_stall_if || i_clear_if);

    assign o_imem_req_valid = w_req_valid;
    assign o_imem_req_addr  = r_fpc;
    assign o_inst_valid_id  = !w_empty && !i_clear_if;
    assign o_inst_id        = o_inst_valid_id ? r_buf_inst[r_rptr] : NOP_INST;
    assign o_pc_id          = w_empty ? r_pc_last : r_buf_pc[r_rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RESET;
            r_fpc     <= START_ADDR;
            r_rsp_pc  <= START_ADDR;
            r_pc_last <= START_ADDR;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_outst   <= '0;
            r_drop    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc_last <= o_pc_id;
            r_outst   <= r_outst + CW'(w_accept) - CW'(i_imem_rsp_valid);
            if (w_redir) begin
                // Every request still in flight after this cycle belongs to the old path.
                r_fpc    <= w_target;
                r_rsp_pc <= w_target;
                r_wptr   <= '0;
                r_rptr   <= '0;
                r_count  <= '0;
                r_drop   <= r_outst - CW'(i_imem_rsp_valid);
            end else begin
                if (w_accept) r_fpc <= r_fpc + 32'd4;
                if (w_push) begin
                    r_wptr   <= r_wptr + PW'(1);
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_pop) r_rptr <= r_rptr + PW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
                if (i_imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !w_redir && w_push) begin
            r_buf_inst[r_wptr] <= i_imem_rsp_data;
            r_buf_pc[r_wptr]   <= r_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            assert ((r_count != CW'(BUF_DEPTH)) || w_pop);
        end
    end

`ifdef AMA_RISCV_FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_flush;
    logic [31:0] r_perf_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_drop  <= '0;
        end else begin
            if (!o_inst_valid_id && (r_perf_stall != 32'hFFFF_FFFF)) r_perf_stall <= r_perf_stall + 32'd1;
            if (w_redir && (r_perf_flush != 32'hFFFF_FFFF))          r_perf_flush <= r_perf_flush + 32'd1;
            if (w_rsp_drop && (r_perf_drop != 32'hFFFF_FFFF))        r_perf_drop  <= r_perf_drop + 32'd1;
        end
    end

    assign o_perf_stall_cnt = r_perf_stall;
    assign o_perf_flush_cnt = r_perf_flush;
    assign o_perf_drop_cnt  = r_perf_drop;
`endif

endmodule

// File: tb/tb_ama_riscv_fetch.sv
// tb/tb_ama_riscv_fetch.sv - self-checking bench for ama_riscv_fetch

`ifndef PC_SEL_INC4
`define PC_SEL_INC4       2'd0
`endif
`ifndef PC_SEL_ALU
`define PC_SEL_ALU        2'd1
`endif
`ifndef PC_SEL_START_ADDR
`define PC_SEL_START_ADDR 2'd2
`endif

module tb_ama_riscv_fetch;

    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pc_sel;
    logic        pc_we, stall_if, clear_if;
    logic [31:0] alu_out;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] inst_id, pc_id;
    logic        inst_valid;
`ifdef AMA_RISCV_FETCH_PERF_EN
    logic [31:0] perf_stall, perf_flush, perf_drop;
`endif

    always #5 clk = ~clk;

    ama_riscv_fetch #(.START_ADDR(START), .BUF_DEPTH(DEPTH), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .i_pc_sel(pc_sel), .i_pc_we(pc_we), .i_stall_if(stall_if), .i_clear_if(clear_if),
        .i_alu_out(alu_out),
        .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready), .o_imem_req_addr(req_addr),
        .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
        .o_inst_id(inst_id), .o_pc_id(pc_id), .o_inst_valid_id(inst_valid)
`ifdef AMA_RISCV_FETCH_PERF_EN
        , .o_perf_stall_cnt(perf_stall), .o_perf_flush_cnt(perf_flush), .o_perf_drop_cnt(perf_drop)
`endif
    );

    typedef struct { logic [31:0] addr; int due; } imem_t;
    typedef struct { logic [31:0] pc; logic drop; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

    imem_t imem_q[$];
    out_t  m_out[$];
    ent_t  m_buf[$];
    logic [31:0] m_fpc, m_last_pc;
    logic        m_run;
    logic        m_init = 1'b0;
    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic        s_rv, s_iv;
    logic [31:0] s_addr, s_inst, s_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h1357_9BD0;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock: drive at negedge, sample after settle, compare with the model, advance model and IMEM.
    task automatic step(input logic r, input logic [1:0] sel, input logic we, input logic st,
                        input logic cl, input logic [31:0] alu, input logic rdy, input int lat);
        logic        redir, exp_rv, exp_iv, push_it;
        logic [31:0] exp_inst, exp_pc, target;
        out_t        o;
        @(negedge clk);
        rst = r; pc_sel = sel; pc_we = we; stall_if = st; clear_if = cl; alu_out = alu; req_ready = rdy;
        if (!r && imem_q.size() > 0 && imem_q[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = mem_word(imem_q[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        s_rv = req_valid; s_addr = req_addr; s_inst = inst_id; s_iv = inst_valid; s_pc = pc_id;

        redir    = (sel == `PC_SEL_ALU) || (sel == `PC_SEL_START_ADDR);
        target   = (sel == `PC_SEL_ALU) ? (alu & ~32'h3) : START;
        exp_rv   = m_run && we && !redir && ((m_buf.size() + m_out.size()) < DEPTH);
        exp_iv   = (m_buf.size() > 0) && !cl;
        exp_inst = exp_iv ? m_buf[0].inst : NOP;
        exp_pc   = (m_buf.size() > 0) ? m_buf[0].pc : m_last_pc;
        if (m_init) begin
            check32("model_req_valid", {31'd0, s_rv}, {31'd0, exp_rv});
            if (exp_rv) check32("model_req_addr", s_addr, m_fpc);
            check32("model_inst_valid", {31'd0, s_iv}, {31'd0, exp_iv});
            check32("model_inst_id", s_inst, exp_inst);
            check32("model_pc_id", s_pc, exp_pc);
        end

        if (r) begin
            m_buf.delete(); m_out.delete();
            m_fpc = START; m_last_pc = START; m_run = 1'b0; m_init = 1'b1;
            imem_q.delete();
        end else begin
            m_last_pc = exp_pc;
            push_it = 1'b0;
            if (rsp_valid && m_out.size() > 0) begin
                o = m_out.pop_front();
                push_it = !redir && !o.drop;
            end
            if (!redir && m_buf.size() > 0 && (!st || cl)) void'(m_buf.pop_front());
            if (push_it) m_buf.push_back('{o.pc, rsp_data});
            if (exp_rv && rdy) begin
                m_out.push_back('{m_fpc, 1'b0});
                m_fpc = m_fpc + 32'd4;
            end
            if (redir) begin
                m_buf.delete();
                for (int i = 0; i < m_out.size(); i++) m_out[i].drop = 1'b1;
                m_fpc = target;
                m_run = 1'b0;
            end else begin
                m_run = 1'b1;
            end
            if (rsp_valid) void'(imem_q.pop_front());
            if (s_rv && rdy) imem_q.push_back('{s_addr, cyc + lat});
        end
        cyc++;
    endtask

    task automatic idle(input logic rdy, input int lat);
        step(1'b0, `PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'd0, rdy, lat);
    endtask

    task automatic do_reset();
        repeat (3) step(1'b1, `PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 1);
    endtask

    typedef struct {
        logic rst; logic rdy; logic chk;
        logic rv; logic [31:0] addr; logic iv; logic [31:0] pc;
    } vec_t;
    vec_t vecs[18];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        logic found;
        rst = 1'b1; pc_sel = `PC_SEL_INC4; pc_we = 1'b0; stall_if = 1'b0; clear_if = 1'b0;
        alu_out = 32'd0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;

        // Reset, sequential fetch at latency 1, then a 5-cycle ready gap.
        vecs[0]  = '{1, 1, 0, 0, 32'h0,  0, 32'h0};
        vecs[1]  = '{1, 1, 0, 0, 32'h0,  0, 32'h0};
        vecs[2]  = '{1, 1, 0, 0, 32'h0,  0, 32'h0};
        vecs[3]  = '{0, 1, 1, 0, 32'h0,  0, 32'h0};
        vecs[4]  = '{0, 1, 1, 1, 32'h0,  0, 32'h0};
        vecs[5]  = '{0, 1, 1, 1, 32'h4,  0, 32'h0};
        vecs[6]  = '{0, 1, 1, 0, 32'h0,  1, 32'h0};
        vecs[7]  = '{0, 1, 1, 1, 32'h8,  1, 32'h4};
        vecs[8]  = '{0, 1, 1, 1, 32'hC,  0, 32'h4};
        vecs[9]  = '{0, 1, 1, 0, 32'h0,  1, 32'h8};
        vecs[10] = '{0, 0, 1, 1, 32'h10, 1, 32'hC};
        vecs[11] = '{0, 0, 1, 1, 32'h10, 0, 32'hC};
        vecs[12] = '{0, 0, 1, 1, 32'h10, 0, 32'hC};
        vecs[13] = '{0, 0, 1, 1, 32'h10, 0, 32'hC};
        vecs[14] = '{0, 0, 1, 1, 32'h10, 0, 32'hC};
        vecs[15] = '{0, 1, 1, 1, 32'h10, 0, 32'hC};
        vecs[16] = '{0, 1, 1, 1, 32'h14, 0, 32'hC};
        vecs[17] = '{0, 1, 1, 0, 32'h0,  1, 32'h10};
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, `PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'd0, vecs[i].rdy, 1);
            if (vecs[i].chk) begin
                check32("vec_req_valid", {31'd0, s_rv}, {31'd0, vecs[i].rv});
                if (vecs[i].rv) check32("vec_req_addr", s_addr, vecs[i].addr);
                check32("vec_inst_valid", {31'd0, s_iv}, {31'd0, vecs[i].iv});
                check32("vec_pc_id", s_pc, vecs[i].pc);
                check32("vec_inst_id", s_inst, vecs[i].iv ? mem_word(vecs[i].pc) : NOP);
            end
        end

        // Stall fills the buffer, release pops one, clear pops the next.
        do_reset();
        for (int k = 0; k <= 10; k++) begin
            step(1'b0, `PC_SEL_INC4, 1'b1, (k <= 6), (k == 8), 32'd0, 1'b1, 1);
            if (k >= 3 && k <= 7) begin
                check32("stall_hold_valid", {31'd0, s_iv}, 32'd1);
                check32("stall_hold_pc", s_pc, 32'h0);
            end
            if (k >= 4 && k <= 7) check32("stall_no_req", {31'd0, s_rv}, 32'd0);
            if (k == 8) begin
                check32("clear_inst", s_inst, NOP);
                check32("clear_valid", {31'd0, s_iv}, 32'd0);
                check32("clear_pc", s_pc, 32'h4);
            end
            if (k == 10) begin
                check32("after_clear_valid", {31'd0, s_iv}, 32'd1);
                check32("after_clear_pc", s_pc, 32'h8);
            end
        end

        // Redirect with two requests outstanding.
        do_reset();
        idle(1'b1, 3);
        idle(1'b1, 3);
        idle(1'b1, 3);
        check32("redir_pre_addr", s_addr, 32'h4);
        step(1'b0, `PC_SEL_ALU, 1'b1, 1'b0, 1'b0, 32'h103, 1'b1, 1);
        check32("redir_cycle_no_req", {31'd0, s_rv}, 32'd0);
        idle(1'b1, 1);
        check32("redir_state_no_req", {31'd0, s_rv}, 32'd0);
        check32("redir_state_invalid", {31'd0, s_iv}, 32'd0);
        idle(1'b1, 1);
        check32("redir_req_valid", {31'd0, s_rv}, 32'd1);
        check32("redir_req_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            idle(1'b1, 1);
            if (s_iv) found = 1'b1;
        end
        check32("redir_found", {31'd0, found}, 32'd1);
        check32("redir_first_pc", s_pc, 32'h100);
        check32("redir_first_inst", s_inst, mem_word(32'h100));

        // Reset with two requests outstanding.
        do_reset();
        idle(1'b1, 3);
        idle(1'b1, 3);
        idle(1'b1, 3);
        step(1'b1, `PC_SEL_INC4, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 3);
        idle(1'b1, 1);
        check32("rst_mid_req_valid", {31'd0, s_rv}, 32'd0);
        check32("rst_mid_inst", s_inst, NOP);
        check32("rst_mid_valid", {31'd0, s_iv}, 32'd0);
        check32("rst_mid_pc", s_pc, START);
        idle(1'b1, 1);
        check32("rst_restart_valid", {31'd0, s_rv}, 32'd1);
        check32("rst_restart_addr", s_addr, START);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            idle(1'b1, 1);
            if (s_iv) found = 1'b1;
        end
        check32("rst_restart_found", {31'd0, found}, 32'd1);
        check32("rst_restart_pc", s_pc, START);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int          r;
            logic [1:0]  sel;
            r = $urandom_range(0, 99);
            sel = (r < 3) ? `PC_SEL_ALU : (r < 4) ? `PC_SEL_START_ADDR : `PC_SEL_INC4;
            step(($urandom_range(0, 499) == 0), sel, ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), $urandom,
                 ($urandom_range(0, 3) != 0), $urandom_range(1, 3));
            if (s_rv) check32("rand_addr_aligned", {30'd0, s_addr[1:0]}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
